// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_pkg
// Purpose  : Shared opcode values, FSM state encoding and instruction field
//            positions for the ALU sequencer and the ALU it drives.
// Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREGS      = 8;
  localparam int REG_AW     = 3;

  // Opcode values, shared with the ALU.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLT = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h3;
  localparam logic [3:0] OP_SLR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_MV  = 4'h6;
  localparam logic [3:0] OP_MVI = 4'h7;

  // Instruction word field positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 9;
  localparam int RY_MSB  = 8;
  localparam int RY_LSB  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  // Opcodes 0..5 go through the ALU; 6/7 are moves, 8..15 are illegal.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_AND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Purpose  : Run/Done handshake toward the instruction source plus the
//            initiator side of the ALU operand/result bus.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
  parameter int DATA_W = alu_sequencer_pkg::DATA_W_DEF
) ();

  logic              run;
  logic [DATA_W-1:0] din;
  logic              done;
  logic              err;
  logic              busy;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_result;

  // Instruction source and ALU side.
  modport master (
    output run, din, alu_result,
    input  done, err, busy, alu_a, alu_b, alu_op
  );

  // Sequencer side.
  modport slave (
    input  run, din, alu_result,
    output done, err, busy, alu_a, alu_b, alu_op
  );

endinterface
`default_nettype wire

// File: rtl/alu_sequencer_reg_bank8.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank8
// Purpose  : 8 x DATA_W register file, asynchronous clear, one write port and
//            three combinational read ports (Rx, Ry, debug).
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank8
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] rx_sel,
  output logic [DATA_W-1:0] rx_data,
  input  logic [REG_AW-1:0] ry_sel,
  output logic [DATA_W-1:0] ry_data,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Single write port; reset clears every entry regardless of a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rx_data  = regs[rx_sel];
  assign ry_data  = regs[ry_sel];
  assign dbg_data = regs[dbg_sel];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle controller for the 16-bit ALU: fetches an
//            instruction, presents operands, captures the result and writes it
//            back to the internal register bank.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic              done_q;
  logic              err_q;

  logic              load_ir;
  logic              load_a;
  logic              load_g;
  logic              done_nxt;
  logic              err_nxt;
  logic              we;
  logic [DATA_W-1:0] wdata;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] ry_data;

  // The low instruction bits carry no meaning.
  logic              unused_ir_bits;

  assign opcode         = ir[OPC_MSB:OPC_LSB];
  assign rx             = ir[RX_MSB:RX_LSB];
  assign ry             = ir[RY_MSB:RY_LSB];
  assign unused_ir_bits = ^ir[RY_LSB-1:0];

  reg_bank8 #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (rx),
    .wdata    (wdata),
    .rx_sel   (rx),
    .rx_data  (rx_data),
    .ry_sel   (ry),
    .ry_data  (ry_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction, operand and result latches plus the registered Done/Err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      a_q    <= '0;
      g_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (load_ir) ir  <= bus.din;
      if (load_a)  a_q <= rx_data;
      if (load_g)  g_q <= bus.alu_result;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  // Next-state and control decode; the single register write of an
  // instruction always happens on its completing edge.
  always_comb begin
    state_nxt = state;
    load_ir   = 1'b0;
    load_a    = 1'b0;
    load_g    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    we        = 1'b0;
    wdata     = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.run) begin
          load_ir   = 1'b1;
          state_nxt = ST_T1;
        end
      end
      ST_T1: begin
        if (opcode == OP_MV) begin
          we        = 1'b1;
          wdata     = ry_data;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (opcode == OP_MVI) begin
          we        = 1'b1;
          wdata     = bus.din;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (is_alu_op(opcode)) begin
          load_a    = 1'b1;
          state_nxt = ST_T2;
        end else begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_T2: begin
        load_g    = 1'b1;
        state_nxt = ST_T3;
      end
      ST_T3: begin
        we        = 1'b1;
        wdata     = g_q;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.alu_a  = a_q;
  assign bus.alu_b  = ry_data;
  assign bus.alu_op = opcode;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with a transaction-level
//            reference model and a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_sequencer_if #(.DATA_W(16)) bus ();

  alu_sequencer #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU, also the arithmetic reference for the model.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return (a < b) ? 16'd1 : 16'd0;
      4'h3:    return (b >= 16) ? 16'd0 : (a << b);
      4'h4:    return (b >= 16) ? 16'd0 : (a >> b);
      4'h5:    return a & b;
      default: return 16'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  // Edges from the Run-accept edge to the completing edge.
  function automatic int latency(input logic [3:0] op);
    return (op <= 4'h5) ? 3 : 1;
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] m_regs [8];
  logic [15:0] m_ir   = '0;
  logic [15:0] m_a    = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;

  initial for (int i = 0; i < 8; i++) m_regs[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_ir = '0; m_a = '0; m_left = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_left == 0) begin
        if (bus.run) begin
          m_ir   = bus.din;
          m_left = latency(bus.din[15:12]);
        end
      end else begin
        if (m_left == 3) m_a = m_regs[m_ir[11:9]];
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1'b1;
          if (m_ir[15])               m_err = 1'b1;
          else if (m_ir[15:12] == 6)  m_regs[m_ir[11:9]] = m_regs[m_ir[8:6]];
          else if (m_ir[15:12] == 7)  m_regs[m_ir[11:9]] = bus.din;
          else m_regs[m_ir[11:9]] = alu_fn(m_ir[15:12], m_a, m_regs[m_ir[8:6]]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_done", 16'(bus.done), 16'd0);
      chk("rst_err", 16'(bus.err), 16'd0);
      chk("rst_alu_a", bus.alu_a, 16'd0);
      chk("rst_alu_b", bus.alu_b, 16'd0);
      chk("rst_alu_op", 16'(bus.alu_op), 16'd0);
      chk("rst_dbg", dbg_data, 16'd0);
    end else begin
      chk("busy", 16'(bus.busy), 16'(m_left != 0));
      chk("done", 16'(bus.done), 16'(m_done));
      chk("err", 16'(bus.err), 16'(m_err));
      chk("alu_op", 16'(bus.alu_op), 16'(m_ir[15:12]));
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_regs[m_ir[8:6]]);
      chk("dbg_data", dbg_data, m_regs[dbg_sel]);
    end
  end

  task automatic chk_reg(input logic [2:0] idx, input logic [15:0] exp);
    dbg_sel = idx;
    @(negedge clk);
    chk("reg_dut", dbg_data, exp);
    chk("reg_model", m_regs[idx], exp);
  endtask

  // Issue one instruction from IDLE and wait (bounded) until it completes.
  // Run/DIN are randomised while busy to show they are ignored.
  task automatic issue(input logic [15:0] instr, input logic [15:0] imm);
    int n;
    bit fin;
    bus.run = 1'b1;
    bus.din = instr;
    dbg_sel = 3'($urandom);
    @(posedge clk); #1;
    bus.run = 1'($urandom);
    bus.din = imm;
    dbg_sel = 3'($urandom);
    n   = 0;
    fin = 1'b0;
    while (!fin && n < 8) begin
      @(posedge clk); #1;
      if (!bus.busy) begin
        fin = 1'b1;
      end else begin
        bus.run = 1'($urandom);
        bus.din = 16'($urandom);
        dbg_sel = 3'($urandom);
        n++;
      end
    end
    bus.run = 1'b0;
    if (!fin) chk("issue_timeout", 16'(bus.busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog busy=%0b", bus.busy);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] instr;
    logic [15:0] imm;
    bus.run = 1'b0;
    bus.din = '0;
    dbg_sel = '0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;

    // mvi R1, 5
    issue(16'h7200, 16'h0005);
    chk("mvi_done", 16'(bus.done), 16'd1);
    chk("mvi_err", 16'(bus.err), 16'd0);
    chk_reg(3'd1, 16'h0005);

    // add R1,R2 with literal operand checks in T2
    issue(16'h7400, 16'h0003);
    bus.run = 1'b1; bus.din = 16'h0280;
    @(posedge clk); #1; bus.run = 1'b0;
    chk("add_t1_busy", 16'(bus.busy), 16'd1);
    @(posedge clk); #1;
    chk("add_t2_a", bus.alu_a, 16'd5);
    chk("add_t2_b", bus.alu_b, 16'd3);
    chk("add_t2_op", 16'(bus.alu_op), 16'd0);
    @(posedge clk); #1;
    chk("add_t3_done", 16'(bus.done), 16'd0);
    @(posedge clk); #1;
    chk("add_done", 16'(bus.done), 16'd1);
    chk("add_busy", 16'(bus.busy), 16'd0);
    chk_reg(3'd1, 16'h0008);

    // slt, sub wrap, sll by 16
    issue(16'h7200, 16'h0002); issue(16'h7400, 16'h0005); issue(16'h2280, 16'h0);
    chk_reg(3'd1, 16'h0001);
    issue(16'h7200, 16'h0000); issue(16'h7400, 16'h0001); issue(16'h1280, 16'h0);
    chk_reg(3'd1, 16'hFFFF);
    issue(16'h7200, 16'h0001); issue(16'h7400, 16'h0010); issue(16'h3280, 16'h0);
    chk_reg(3'd1, 16'h0000);

    // illegal opcode
    issue(16'hF000, 16'h1234);
    chk("ill_done", 16'(bus.done), 16'd1);
    chk("ill_err", 16'(bus.err), 16'd1);
    chk_reg(3'd1, 16'h0000);
    chk_reg(3'd2, 16'h0010);
    issue(16'h7600, 16'h00AA);
    chk("legal_err", 16'(bus.err), 16'd0);
    chk("legal_done", 16'(bus.done), 16'd1);

    // Run held high: mv R3,R1 then add R3,R3
    issue(16'h7200, 16'h0004);
    bus.run = 1'b1; bus.din = 16'h6640;
    @(posedge clk); #1; bus.din = 16'h06C0;
    @(posedge clk); #1;
    chk("hold_mv_done", 16'(bus.done), 16'd1);
    @(posedge clk); #1;
    chk("hold_add_busy", 16'(bus.busy), 16'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.run = 1'b0;
    chk("hold_add_done", 16'(bus.done), 16'd1);
    chk_reg(3'd3, 16'h0008);

    // asynchronous reset in T2 of an add
    issue(16'h7200, 16'h0007);
    bus.run = 1'b1; bus.din = 16'h0280;
    @(posedge clk); #1; bus.run = 1'b0; dbg_sel = 3'd1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 16'(bus.busy), 16'd0);
    chk("arst_done", 16'(bus.done), 16'd0);
    chk("arst_r1", dbg_data, 16'd0);
    chk("arst_op", 16'(bus.alu_op), 16'd0);
    @(negedge clk); #2 rst = 1'b0;
    chk_reg(3'd1, 16'h0000);
    chk_reg(3'd2, 16'h0000);
    issue(16'h7200, 16'h0009);
    chk_reg(3'd1, 16'h0009);

    // randomised instruction stream
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom);
      if (op[3] && $urandom_range(0, 3) != 0) op[3] = 1'b0;
      instr = {op, 3'($urandom), 3'($urandom), 6'($urandom)};
      imm   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      issue(instr, imm);
    end
    for (int r = 0; r < 8; r++) begin
      dbg_sel = 3'(r);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
